corr_frame_scheduler: RTL

Sequences the HLS correlator kernel through its `ap_ctrl_hs` handshake. It launches a configured number of frames per integration, then requests a visibility dump and waits for its acknowledgement. A stall watchdog, driven by the `block` output of the co-simulation deadlock monitor tree, moves the scheduler to a sticky fault state if the kernel stays blocked too long. The block sits between the host/test controller and the correlator top-level control port.

---
 rtl/corr_frame_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/corr_frame_scheduler.sv
// corr_frame_scheduler
//
// Sequences the HLS correlator kernel through its ap_ctrl_hs handshake:
// launches cfg_frames frames per integration, then requests a visibility
// dump and waits for the acknowledgement. Optionally loops integrations
// back-to-back. A stall watchdog fed by the deadlock monitor's block
// indication forces a sticky FAULT state if the kernel stays blocked.
//
// Ports:
//   clock, reset           clock (rising edge), asynchronous active-high reset
//   go, stop               start pulse (IDLE only); stop level (checked at dump ack)
//   cfg_continuous         loop integrations, latched at go
//   cfg_frames             frames per integration, latched at go (0 -> 1)
//   ap_start/ap_ready/ap_done  kernel control handshake
//   dump_req/dump_ack      visibility dump handshake
//   block_in               deadlock-monitor block indication
//   clear_fault            leave FAULT
//   busy, err_deadlock     status (busy = not IDLE, sticky deadlock fault)
//   frame_cnt, integ_cnt   frames in current integration, integrations since reset
module corr_frame_scheduler #(
  parameter int FRAMES_W   = 16,
  parameter int INTEG_W    = 16,
  parameter int WDOG_W     = 20,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                stop,
  input  logic                cfg_continuous,
  input  logic [FRAMES_W-1:0] cfg_frames,
  output logic                ap_start,
  input  logic                ap_ready,
  input  logic                ap_done,
  output logic                dump_req,
  input  logic                dump_ack,
  input  logic                block_in,
  input  logic                clear_fault,
  output logic                busy,
  output logic                err_deadlock,
  output logic [FRAMES_W-1:0] frame_cnt,
  output logic [INTEG_W-1:0]  integ_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DUMP,
    ST_FAULT
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_LIMIT_V = WDOG_W'(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_MAX     = '1;

  state_t              state_reg, state_next;
  logic [FRAMES_W-1:0] frames_cfg_reg, frames_cfg_next;
  logic                continuous_reg, continuous_next;
  logic [FRAMES_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [INTEG_W-1:0]  integ_cnt_reg, integ_cnt_next;
  logic [WDOG_W-1:0]   wdog_reg, wdog_next;
  logic                ap_start_reg, ap_start_next;
  logic                dump_req_reg, dump_req_next;
  logic                busy_reg, busy_next;
  logic                err_reg, err_next;

  logic                fault_trip;
  logic [FRAMES_W-1:0] frame_inc;

  assign frame_inc = frame_cnt_reg + FRAMES_W'(1);

  // Watchdog: counts consecutive blocked cycles while the kernel is active.
  // It trips when a further blocked cycle is seen with the counter already
  // at the limit, so limit+1 consecutive blocked cycles cause the fault and
  // a single unblocked cycle at the limit does not.
  always_comb begin
    wdog_next  = wdog_reg;
    fault_trip = 1'b0;
    case (state_reg)
      ST_LAUNCH, ST_RUN, ST_DUMP: begin
        if (block_in) begin
          fault_trip = (wdog_reg >= WDOG_LIMIT_V);
          wdog_next  = (wdog_reg == WDOG_MAX) ? wdog_reg : wdog_reg + WDOG_W'(1);
        end else begin
          wdog_next = '0;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          wdog_next = '0;
        end
      end
      default: wdog_next = '0;
    endcase
  end

  // Next-state and counter logic.
  always_comb begin
    state_next      = state_reg;
    frames_cfg_next = frames_cfg_reg;
    continuous_next = continuous_reg;
    frame_cnt_next  = frame_cnt_reg;
    integ_cnt_next  = integ_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          frames_cfg_next = (cfg_frames == '0) ? FRAMES_W'(1) : cfg_frames;
          continuous_next = cfg_continuous;
          frame_cnt_next  = '0;
          state_next      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (ap_ready) begin
          // A done in the same cycle as ready completes the frame at once.
          if (ap_done) begin
            frame_cnt_next = frame_inc;
            state_next     = (frame_inc == frames_cfg_reg) ? ST_DUMP : ST_LAUNCH;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (ap_done) begin
          frame_cnt_next = frame_inc;
          state_next     = (frame_inc == frames_cfg_reg) ? ST_DUMP : ST_LAUNCH;
        end
      end
      ST_DUMP: begin
        if (dump_ack) begin
          integ_cnt_next = integ_cnt_reg + INTEG_W'(1);
          frame_cnt_next = '0;
          state_next     = (continuous_reg && !stop) ? ST_LAUNCH : ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          frame_cnt_next = '0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The watchdog overrides everything, including counter updates.
    if (fault_trip) begin
      state_next     = ST_FAULT;
      frame_cnt_next = frame_cnt_reg;
      integ_cnt_next = integ_cnt_reg;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    ap_start_next = (state_next == ST_LAUNCH);
    dump_req_next = (state_next == ST_DUMP);
    busy_next     = (state_next != ST_IDLE);
    err_next      = (state_next == ST_FAULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      frames_cfg_reg <= FRAMES_W'(1);
      continuous_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      integ_cnt_reg  <= '0;
      wdog_reg       <= '0;
      ap_start_reg   <= 1'b0;
      dump_req_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frames_cfg_reg <= frames_cfg_next;
      continuous_reg <= continuous_next;
      frame_cnt_reg  <= frame_cnt_next;
      integ_cnt_reg  <= integ_cnt_next;
      wdog_reg       <= wdog_next;
      ap_start_reg   <= ap_start_next;
      dump_req_reg   <= dump_req_next;
      busy_reg       <= busy_next;
      err_reg        <= err_next;
    end
  end

  assign ap_start     = ap_start_reg;
  assign dump_req     = dump_req_reg;
  assign busy         = busy_reg;
  assign err_deadlock = err_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign integ_cnt    = integ_cnt_reg;

endmodule
